lfsr_check: RTL

Stream sink that consumes frames produced by `lfsr_source` (directly or after a DUT/loopback path) and checks them against a locally regenerated reference pattern: LFSR, counter, ones or zeros. Counts received words, frames, data-mismatch words and frame-length violations, and records the index of the first mismatch. Configured and read back over the same 32-bit APB register interface style as the source. Single clock domain, so no synchronisers are needed.

---
 rtl/lfsr_check_pkg.sv | 36 +++
 rtl/lfsr17_shift.sv | 36 +++
 rtl/lfsr_check.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_check_pkg.sv
// Shared register map, pattern encoding and width helper for the LFSR stream checker.
package lfsr_check_pkg;

  typedef logic [1:0] pattern_t;

  localparam pattern_t PAT_LFSR    = 2'd0;
  localparam pattern_t PAT_COUNTER = 2'd1;
  localparam pattern_t PAT_ONES    = 2'd2;
  localparam pattern_t PAT_ZEROS   = 2'd3;

  typedef logic [3:0] reg_addr_t;

  localparam reg_addr_t REG_ENABLE        = 4'd0;
  localparam reg_addr_t REG_RX_COUNT      = 4'd1;
  localparam reg_addr_t REG_CLR           = 4'd2;
  localparam reg_addr_t REG_REPEAT        = 4'd3;
  localparam reg_addr_t REG_LENGTH        = 4'd4;
  localparam reg_addr_t REG_PATTERN       = 4'd5;
  localparam reg_addr_t REG_ERR_COUNT     = 4'd6;
  localparam reg_addr_t REG_FRAME_COUNT   = 4'd7;
  localparam reg_addr_t REG_LEN_ERR_COUNT = 4'd8;
  localparam reg_addr_t REG_FIRST_ERR_IDX = 4'd9;

  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits = bits + 1;
      rem  = rem >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/lfsr17_shift.sv
// 17-bit LFSR (x^17 + x^14 + 1) advanced DataBits steps per shift; dout is the current word.
// Shared with the source so both ends produce bit-identical sequences.
module lfsr17_shift #(
  parameter int          DataBits = 8,
  parameter logic [16:0] Seed     = 17'h15555
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init,
  input  logic                shift,
  output logic [DataBits-1:0] dout
);

  logic [16:0] state;
  logic [16:0] state_nxt;

  always_comb begin
    state_nxt = state;
    for (int i = 0; i < DataBits; i++) begin
      state_nxt = {state_nxt[15:0], state_nxt[16] ^ state_nxt[13]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= Seed;
    end else if (init) begin
      state <= Seed;
    end else if (shift) begin
      state <= state_nxt;
    end
  end

  assign dout = state[DataBits-1:0];

endmodule

// File: rtl/lfsr_check.sv
// Stream sink that checks received frames against a regenerated LFSR/counter/constant pattern
// and keeps saturating word, frame, data-error and length-error counters readable over APB.
module lfsr_check
  import lfsr_check_pkg::*;
#(
  parameter int          DataBits       = 8,
  parameter int          CountBits      = 32,
  parameter int          MaxLength      = 1024,
  parameter bit          EnableDefault  = 1'b0,
  parameter bit          RepeatDefault  = 1'b0,
  parameter int          PatternDefault = 0,
  parameter logic [16:0] LfsrSeed       = 17'h15555
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          cfg_paddr,
  input  logic                cfg_pwrite,
  input  logic                cfg_psel,
  input  logic                cfg_penable,
  input  logic [31:0]         cfg_pwdata,
  output logic                cfg_pready,
  output logic [31:0]         cfg_prdata,
  output logic                cfg_pslverr,
  input  logic                din_valid,
  output logic                din_ready,
  input  logic [DataBits-1:0] din_data,
  input  logic                din_eof
);

  localparam int          LenBits  = clog2(MaxLength + 1);
  localparam logic [31:0] MaxLen32 = 32'(MaxLength);

  logic                 enable;
  logic                 clr;
  logic                 rep_en;
  logic [LenBits-1:0]   length;
  pattern_t             pattern;

  logic [CountBits-1:0] rx_count;
  logic [CountBits-1:0] frame_count;
  logic [CountBits-1:0] err_count;
  logic [CountBits-1:0] len_err_count;
  logic [CountBits-1:0] first_err_idx;

  logic [LenBits-1:0]   len_count;
  logic [LenBits:0]     len_next;
  logic                 len_flag;
  logic                 len_viol;

  logic [DataBits-1:0]  cnt_gen;
  logic [DataBits-1:0]  lfsr_word;
  logic [DataBits-1:0]  exp_word;
  logic                 lfsr_rst;

  logic                 s1_vld;
  logic [DataBits-1:0]  s1_data;
  logic [DataBits-1:0]  s1_exp;
  logic [CountBits-1:0] s1_idx;

  logic                 apb_setup;
  logic                 apb_wr;
  logic                 apb_rd;
  reg_addr_t            apb_word;
  logic [31:0]          rd_val;
  logic                 rd_hit;
  logic [LenBits-1:0]   len_wr;
  logic                 accept;
  logic                 unused_paddr;

  function automatic logic [CountBits-1:0] sat_inc(input logic [CountBits-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

  assign cfg_pready   = 1'b1;
  assign cfg_pslverr  = 1'b0;
  assign apb_setup    = cfg_psel & ~cfg_penable;
  assign apb_wr       = apb_setup & cfg_pwrite;
  assign apb_rd       = apb_setup & ~cfg_pwrite;
  assign apb_word     = cfg_paddr[5:2];
  assign unused_paddr = ^cfg_paddr[1:0];

  // Length is clamped into [2, MaxLength] on write.
  always_comb begin
    len_wr = LenBits'(MaxLength);
    if (cfg_pwdata < 32'd2) begin
      len_wr = LenBits'(2);
    end else if (cfg_pwdata <= MaxLen32) begin
      len_wr = cfg_pwdata[LenBits-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable  <= EnableDefault;
      clr     <= 1'b0;
      rep_en  <= RepeatDefault;
      length  <= LenBits'(MaxLength);
      pattern <= pattern_t'(PatternDefault);
    end else if (apb_wr) begin
      case (apb_word)
        REG_ENABLE:  enable  <= cfg_pwdata[0];
        REG_CLR:     clr     <= cfg_pwdata[0];
        REG_REPEAT:  rep_en  <= cfg_pwdata[0];
        REG_LENGTH:  length  <= len_wr;
        REG_PATTERN: pattern <= cfg_pwdata[1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    rd_hit = 1'b1;
    case (apb_word)
      REG_ENABLE:        rd_val = 32'(enable);
      REG_RX_COUNT:      rd_val = 32'(rx_count);
      REG_CLR:           rd_val = 32'(clr);
      REG_REPEAT:        rd_val = 32'(rep_en);
      REG_LENGTH:        rd_val = 32'(length);
      REG_PATTERN:       rd_val = 32'(pattern);
      REG_ERR_COUNT:     rd_val = 32'(err_count);
      REG_FRAME_COUNT:   rd_val = 32'(frame_count);
      REG_LEN_ERR_COUNT: rd_val = 32'(len_err_count);
      REG_FIRST_ERR_IDX: rd_val = 32'(first_err_idx);
      default:           rd_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_prdata <= '0;
    end else if (apb_rd && rd_hit) begin
      cfg_prdata <= rd_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_ready <= 1'b0;
    end else begin
      din_ready <= enable & ~clr;
    end
  end

  assign accept = din_valid & din_ready;

  // Reference generators; Clr restarts both exactly as a reset would.
  assign lfsr_rst = rst | clr;

  lfsr17_shift #(
    .DataBits (DataBits),
    .Seed     (LfsrSeed)
  ) u_lfsr (
    .clk   (clk),
    .rst   (lfsr_rst),
    .init  (accept & din_eof & rep_en),
    .shift (accept),
    .dout  (lfsr_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_gen <= '0;
    end else if (clr) begin
      cnt_gen <= '0;
    end else if (accept) begin
      cnt_gen <= (din_eof && rep_en) ? '0 : cnt_gen + 1'b1;
    end
  end

  always_comb begin
    exp_word = lfsr_word;
    case (pattern)
      PAT_LFSR:    exp_word = lfsr_word;
      PAT_COUNTER: exp_word = cnt_gen;
      PAT_ONES:    exp_word = '1;
      PAT_ZEROS:   exp_word = '0;
      default:     exp_word = lfsr_word;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
      s1_exp  <= '0;
      s1_idx  <= '0;
    end else if (clr) begin
      s1_vld  <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_data <= din_data;
        s1_exp  <= exp_word;
        s1_idx  <= rx_count;
      end
    end
  end

  // len_count saturates, so the extra top bit keeps len_next from aliasing onto Length.
  assign len_next = (LenBits + 1)'(len_count) + 1'b1;
  assign len_viol = din_eof ? (len_next != (LenBits + 1)'(length))
                            : (len_next == (LenBits + 1)'(length));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_count      <= '0;
      frame_count   <= '0;
      err_count     <= '0;
      len_err_count <= '0;
      first_err_idx <= '1;
      len_count     <= '0;
      len_flag      <= 1'b0;
    end else if (clr) begin
      rx_count      <= '0;
      frame_count   <= '0;
      err_count     <= '0;
      len_err_count <= '0;
      first_err_idx <= '1;
      len_count     <= '0;
      len_flag      <= 1'b0;
    end else begin
      if (accept) begin
        rx_count <= sat_inc(rx_count);
        if (len_viol && !len_flag) begin
          len_err_count <= sat_inc(len_err_count);
        end
        if (din_eof) begin
          frame_count <= sat_inc(frame_count);
          len_count   <= '0;
          len_flag    <= 1'b0;
        end else begin
          len_count <= (&len_count) ? len_count : len_count + 1'b1;
          if (len_viol) begin
            len_flag <= 1'b1;
          end
        end
      end
      if (s1_vld && (s1_data != s1_exp)) begin
        err_count <= sat_inc(err_count);
        if (&first_err_idx) begin
          first_err_idx <= s1_idx;
        end
      end
    end
  end

endmodule
